xps2_tx: RTL and testbench

XPS2_TX -- requirements
Module: xps2_tx

---
 rtl/xps2_tx.sv | 246 ++++++++++++++++++++++++
 tb/tb_xps2_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/xps2_tx.sv
// ---------------------------------------------------------------------------
// xps2_tx -- PS/2 host-to-device byte transmitter
//
// A bus write in IDLE latches one byte. The block then inhibits the PS/2
// clock, presents the start bit and releases the clock. It shifts out data
// (LSB first), odd parity and stop on successive device clock falling edges.
// Finally it samples the device acknowledge and waits for the bus to go idle.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   sel, we      bus select / write enable; sel & we in IDLE starts a frame
//   data_in      byte to transmit
//   data_out     status {err, done, busy, last accepted byte}
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low (open drain), registered
//   ps2_data_oe  1 = pull PS/2 data low (open drain), registered
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module xps2_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [7:0]  data_in,
  output logic [10:0] data_out,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_XFER      = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // One counter serves both the inhibit period and the edge timeout, since
  // the two are never needed at the same time.
  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  // Synchronizers; reset to 1 so an idle bus never looks like a falling edge
  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_data_meta, r_data_sync;

  // State and datapath registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_byte;
  logic             r_parity;
  logic             r_done;
  logic             r_err;
  logic             r_clk_oe;
  logic             r_data_oe;

  // Next-state values
  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       w_bit_nx;
  logic [7:0]       w_byte_nx;
  logic             w_parity_nx;
  logic             w_done_nx;
  logic             w_err_nx;
  logic             w_clk_oe_nx;
  logic             w_data_oe_nx;

  logic             w_fall;
  logic             w_wr;
  logic             w_busy;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  assign w_wr      = sel & we;
  assign w_busy    = (r_state != S_IDLE);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (r_cnt == TO_LAST);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_bit_nx     = r_bit_cnt;
    w_byte_nx    = r_byte;
    w_parity_nx  = r_parity;
    w_done_nx    = r_done;
    w_err_nx     = r_err;
    w_clk_oe_nx  = r_clk_oe;
    w_data_oe_nx = r_data_oe;

    case (r_state)
      S_IDLE: begin
        if (w_wr) begin
          w_byte_nx    = data_in;
          w_parity_nx  = ~^data_in;
          w_done_nx    = 1'b0;
          w_err_nx     = 1'b0;
          w_cnt_nx     = '0;
          w_bit_nx     = 4'd0;
          w_clk_oe_nx  = 1'b1;
          // A one-cycle inhibit makes its only cycle the start-bit cycle
          w_data_oe_nx = (INH_LAST == '0);
          w_state_nx   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt_nx    = '0;
          w_clk_oe_nx = 1'b0;
          w_state_nx  = S_XFER;
        end else begin
          w_cnt_nx = w_cnt_inc;
          // Start bit goes out during the final inhibit cycle
          if (w_cnt_inc == INH_LAST) begin
            w_data_oe_nx = 1'b1;
          end
        end
      end

      S_XFER: begin
        if (w_fall) begin
          w_cnt_nx = '0;
          w_bit_nx = r_bit_cnt + 4'd1;
          // r_bit_cnt holds the number of edges already seen (0..9)
          if (r_bit_cnt < 4'd8) begin
            w_data_oe_nx = ~r_byte[r_bit_cnt[2:0]];
          end else if (r_bit_cnt == 4'd8) begin
            w_data_oe_nx = ~r_parity;
          end else begin
            w_data_oe_nx = 1'b0;  // stop bit: release data
            w_state_nx   = S_ACK;
          end
        end else if (w_timeout) begin
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_err_nx     = 1'b1;
          w_done_nx    = 1'b0;
          w_cnt_nx     = '0;
          w_bit_nx     = 4'd0;
          w_state_nx   = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      S_ACK: begin
        if (w_fall) begin
          w_cnt_nx   = '0;
          w_err_nx   = r_data_sync;  // device must hold data low to ack
          w_state_nx = S_WAIT_IDLE;
        end else if (w_timeout) begin
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_err_nx     = 1'b1;
          w_done_nx    = 1'b0;
          w_cnt_nx     = '0;
          w_bit_nx     = 4'd0;
          w_state_nx   = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      S_WAIT_IDLE: begin
        if (r_clk_sync && r_data_sync) begin
          w_done_nx  = ~r_err;
          w_cnt_nx   = '0;
          w_bit_nx   = 4'd0;
          w_state_nx = S_IDLE;
        end else if (w_fall) begin
          w_cnt_nx = '0;
        end else if (w_timeout) begin
          w_clk_oe_nx  = 1'b0;
          w_data_oe_nx = 1'b0;
          w_err_nx     = 1'b1;
          w_done_nx    = 1'b0;
          w_cnt_nx     = '0;
          w_bit_nx     = 4'd0;
          w_state_nx   = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      default: begin
        w_clk_oe_nx  = 1'b0;
        w_data_oe_nx = 1'b0;
        w_cnt_nx     = '0;
        w_bit_nx     = 4'd0;
        w_state_nx   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= 4'd0;
      r_byte      <= 8'h00;
      r_parity    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
    end else begin
      r_clk_meta  <= ps2_clk_in;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2_data_in;
      r_data_sync <= r_data_meta;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit_cnt   <= w_bit_nx;
      r_byte      <= w_byte_nx;
      r_parity    <= w_parity_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_clk_oe    <= w_clk_oe_nx;
      r_data_oe   <= w_data_oe_nx;
    end
  end

  assign data_out    = {r_err, r_done, w_busy, r_byte};
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_xps2_tx.sv
// ---------------------------------------------------------------------------
// tb_xps2_tx -- directed bench for xps2_tx
//
// Table of {byte, ack, expected line bits, expected final status} records is
// run through a behavioural PS/2 device, followed by hand-written sequences
// for write-while-busy, edge timeout and reset mid-frame.
// Line bits are packed {stop, parity, data[7:0], start}.
// ---------------------------------------------------------------------------
module tb_xps2_tx;

  localparam int INH  = 20;
  localparam int TO   = 400;
  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we;
  logic [7:0]  data_in;
  logic [10:0] data_out;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic [2:0]  dbg_state;

  logic dev_clk_pull  = 1'b0;
  logic dev_data_pull = 1'b0;

  // Open-drain bus with pull-ups: any driver pulling low wins
  assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_pull);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_pull);

  xps2_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .we          (we),
    .data_in     (data_in),
    .data_out    (data_out),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [15:0] act);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected queue empty", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; data_in = b;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  // Device: measures the inhibit, then generates n_edges clock pulses and
  // samples the data line in the high phase before each falling edge.
  // With do_ack it pulls data low ahead of the 11th falling edge.
  task automatic dev_frame(input int n_edges, input bit do_ack,
                           output logic [10:0] bits, output int inh, output int dcnt);
    int t;
    bits = '0; inh = 0; dcnt = 0; t = 0;
    while (!ps2_clk_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (ps2_clk_oe && inh < INH + 100) begin
      inh++;
      if (ps2_data_oe) dcnt++;
      @(negedge clk);
    end
    for (int k = 1; k <= n_edges; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k-1] = ps2_data_in;
      if (k == 11 && do_ack) dev_data_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_pull = 1'b0;
    end
    dev_data_pull = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (data_out[8] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, {15'd0, data_out[8]}, 16'd0);
  endtask

  task automatic run_frame(input logic [7:0] din, input bit ack,
                           input logic [10:0] exp_line, input logic [10:0] exp_status);
    logic [10:0] bits;
    int inh, dcnt;
    exp_q.push_back({5'd0, exp_line});
    exp_q.push_back({5'd0, exp_status});
    do_write(din);
    check("busy_after_write", {5'd0, data_out}, {8'h01, din});
    dev_frame(11, ack, bits, inh, dcnt);
    check("inhibit_len", inh[15:0], INH[15:0]);
    check("start_in_inhibit", dcnt[15:0], 16'd1);
    sb_check("line_bits", {5'd0, bits});
    wait_idle("idle_after_frame");
    sb_check("final_status", {5'd0, data_out});
    check("oe_released", {14'd0, ps2_clk_oe, ps2_data_oe}, 16'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  din;
    bit          ack;
    logic [10:0] exp_line;
    logic [10:0] exp_status;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [10:0] bits;
    int inh, dcnt, t;

    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 11'h2ED};
    vecs[1] = '{8'h00, 1'b1, 11'h600, 11'h200};
    vecs[2] = '{8'hED, 1'b0, 11'h7DA, 11'h4ED};
    vecs[3] = '{8'hA5, 1'b1, 11'h74A, 11'h2A5};
    vecs[4] = '{8'h01, 1'b1, 11'h402, 11'h201};
    vecs[5] = '{8'h07, 1'b0, 11'h40E, 11'h407};

    rst = 1'b1; sel = 1'b0; we = 1'b0; data_in = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_status", {5'd0, data_out}, 16'h0000);
    check("reset_oe", {14'd0, ps2_clk_oe, ps2_data_oe}, 16'd0);
    check("reset_state", {13'd0, dbg_state}, 16'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].din, vecs[i].ack, vecs[i].exp_line, vecs[i].exp_status);
    end

    // Write while busy must be ignored
    exp_q.push_back({5'd0, 11'h754});
    do_write(8'hAA);
    fork
      dev_frame(11, 1'b1, bits, inh, dcnt);
      begin
        repeat (60) @(negedge clk);
        do_write(8'h55);
        check("byte_kept_busy", {5'd0, data_out}, 16'h01AA);
      end
    join
    sb_check("line_bits_aa", {5'd0, bits});
    wait_idle("idle_after_aa");
    check("status_aa", {5'd0, data_out}, 16'h02AA);
    repeat (10) @(negedge clk);
    check("done_sticky", {5'd0, data_out}, 16'h02AA);

    // Device never clocks: timeout about TO cycles after the inhibit
    do_write(8'hF4);
    dev_frame(0, 1'b0, bits, inh, dcnt);
    check("inhibit_len_to", inh[15:0], INH[15:0]);
    t = 0;
    while (data_out[8] && t < TO + 50) begin
      @(negedge clk);
      t++;
    end
    check("timeout_window", {15'd0, (t >= TO - 1) && (t <= TO + 1)}, 16'd1);
    check("timeout_status", {5'd0, data_out}, 16'h04F4);
    check("timeout_oe", {14'd0, ps2_clk_oe, ps2_data_oe}, 16'd0);

    // Reset in the middle of a frame
    do_write(8'hFF);
    check("busy_ff_err_cleared", {5'd0, data_out}, 16'h01FF);
    dev_frame(4, 1'b0, bits, inh, dcnt);
    check("mid_frame_busy", {5'd0, data_out}, 16'h01FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_oe", {14'd0, ps2_clk_oe, ps2_data_oe}, 16'd0);
    check("rst_mid_status", {5'd0, data_out}, 16'h0000);
    @(negedge clk);
    run_frame(8'h12, 1'b1, 11'h624, 11'h212);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL exp_q_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
